// File: rtl/lc_port_arbiter_if.sv
// Bundle of requester, response and memory-side signals around the LLC port arbiter.
// The arbiter uses the slave modport; the surrounding caches/memory model use master.
interface lc_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int LINE_W  = 512
);
  // Every channel is valid/ready: a transfer happens on a rising clk_in edge where
  // both are high; the source holds valid and its payload stable until that edge.
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ-1:0]        req_ready_out;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_in;
  logic [NUM_REQ*LINE_W-1:0] req_value_in;
  logic [NUM_REQ-1:0]        req_we_in;

  logic [NUM_REQ-1:0]        resp_valid_out;
  logic [NUM_REQ-1:0]        resp_ready_in;
  logic [ADDR_W-1:0]         resp_addr_out;
  logic [LINE_W-1:0]         resp_value_out;

  logic                      mem_valid_out;
  logic                      mem_ready_in;
  logic [ADDR_W-1:0]         mem_addr_out;
  logic [LINE_W-1:0]         mem_value_out;
  logic                      mem_we_out;

  logic                      mem_valid_in;
  logic                      mem_ready_out;
  logic [ADDR_W-1:0]         mem_addr_in;
  logic [LINE_W-1:0]         mem_value_in;

  modport slave (
    input  req_valid_in, req_addr_in, req_value_in, req_we_in,
    output req_ready_out,
    output resp_valid_out, resp_addr_out, resp_value_out,
    input  resp_ready_in,
    output mem_valid_out, mem_addr_out, mem_value_out, mem_we_out,
    input  mem_ready_in,
    input  mem_valid_in, mem_addr_in, mem_value_in,
    output mem_ready_out
  );

  modport master (
    output req_valid_in, req_addr_in, req_value_in, req_we_in,
    input  req_ready_out,
    input  resp_valid_out, resp_addr_out, resp_value_out,
    output resp_ready_in,
    input  mem_valid_out, mem_addr_out, mem_value_out, mem_we_out,
    output mem_ready_in,
    output mem_valid_in, mem_addr_in, mem_value_in,
    input  mem_ready_out
  );
endinterface

// File: rtl/lc_port_arbiter.sv
// Round-robin arbiter sharing one LLC/DIMM port between NUM_REQ cache requesters,
// one outstanding transaction at a time, with read fills routed back to their issuer.
module lc_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int LINE_W  = 512,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk_in,
  input  logic             rst_N_in,
  lc_port_arbiter_if.slave bus,
  output logic [1:0]       dbg_state_out,
  output logic [PTR_W-1:0] dbg_rr_ptr_out,
  output logic [PTR_W-1:0] dbg_owner_out
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DELIVER   = 2'd3
  } state_e;

  localparam logic [PTR_W:0]   NUM_REQ_X = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   value_q, value_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   resp_addr_q, resp_addr_d;
  logic [LINE_W-1:0]   resp_value_q, resp_value_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]     grant_off;
  logic [PTR_W:0]       grant_sum;
  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]   owner_mask;
  logic                 resp_take;

  // Rotate the request vector so bit 0 is the rr_ptr requester; the lowest set bit wins.
  always_comb begin
    req_dbl   = {bus.req_valid_in, bus.req_valid_in} >> rr_ptr_q;
    req_rot   = req_dbl[NUM_REQ-1:0];
    grant_vld = |req_rot;
    grant_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) grant_off = PTR_W'(k);
    end
    grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
    if (grant_sum >= NUM_REQ_X) grant_sum = grant_sum - NUM_REQ_X;
    grant_idx = grant_sum[PTR_W-1:0];
  end

  // Ready is combinational from the request, but never while reset is held.
  always_comb begin
    bus.req_ready_out = '0;
    if (rst_N_in && (state_q == ST_IDLE) && grant_vld) begin
      bus.req_ready_out = NUM_REQ'(1) << grant_idx;
    end
  end

  assign owner_mask = NUM_REQ'(1) << owner_q;
  assign resp_take  = |(bus.resp_ready_in & owner_mask);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    value_d      = value_q;
    we_d         = we_q;
    resp_addr_d  = resp_addr_q;
    resp_value_d = resp_value_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
              addr_d  = bus.req_addr_in[i*ADDR_W +: ADDR_W];
              value_d = bus.req_value_in[i*LINE_W +: LINE_W];
              we_d    = bus.req_we_in[i];
            end
          end
          owner_d  = grant_idx;
          rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Writes complete at the memory handshake; only reads expect a fill.
        if (bus.mem_ready_in) state_d = we_q ? ST_IDLE : ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (bus.mem_valid_in) begin
          resp_addr_d  = bus.mem_addr_in;
          resp_value_d = bus.mem_value_in;
          state_d      = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (resp_take) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      addr_q       <= '0;
      value_q      <= '0;
      we_q         <= 1'b0;
      resp_addr_q  <= '0;
      resp_value_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      value_q      <= value_d;
      we_q         <= we_d;
      resp_addr_q  <= resp_addr_d;
      resp_value_q <= resp_value_d;
    end
  end

  assign bus.mem_valid_out  = (state_q == ST_ISSUE);
  assign bus.mem_addr_out   = addr_q;
  assign bus.mem_value_out  = value_q;
  assign bus.mem_we_out     = we_q;
  assign bus.mem_ready_out  = (state_q == ST_WAIT_RESP);
  assign bus.resp_valid_out = (state_q == ST_DELIVER) ? owner_mask : '0;
  assign bus.resp_addr_out  = resp_addr_q;
  assign bus.resp_value_out = resp_value_q;

  assign dbg_state_out  = state_q;
  assign dbg_rr_ptr_out = rr_ptr_q;
  assign dbg_owner_out  = owner_q;

  a_ready_onehot: assert property (@(posedge clk_in) disable iff (!rst_N_in)
    $onehot0(bus.req_ready_out));
  a_resp_onehot: assert property (@(posedge clk_in) disable iff (!rst_N_in)
    $onehot0(bus.resp_valid_out));
  a_mem_hold: assert property (@(posedge clk_in) disable iff (!rst_N_in)
    (bus.mem_valid_out && !bus.mem_ready_in) |=>
      (bus.mem_valid_out && $stable(bus.mem_addr_out) &&
       $stable(bus.mem_value_out) && $stable(bus.mem_we_out)));

endmodule
